// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and default bit timing.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS           = 8;
    localparam int FRAME_BITS          = 10;
    localparam int DEFAULT_CLK_PER_BIT = 100;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte buffer for the UART transmitter: asynchronous-read array,
// power-of-two depth, wrapping pointers and an occupancy counter.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop happens on the same edge.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input buffer. The line register follows
// the FSM state by one cycle, so every bit is still CLK_PER_BIT cycles wide.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       serial_line,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    generate
        if (CLK_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx: CLK_PER_BIT must be at least 2");
        end
    endgenerate

    uart_state_t      state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [7:0]       fifo_data;
    logic             bit_done;

    assign in_ready = !fifo_full;
    assign bit_done = (bit_cnt == CNT_LAST);

    // Pop when leaving IDLE, or at the end of a stop bit for back-to-back frames.
    assign fifo_pop = !fifo_empty &&
                      ((state == ST_IDLE) || (state == ST_STOP && bit_done));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Frame sequencer: bit timing, data shifting and the registered line/busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            serial_line <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_START: serial_line <= 1'b0;
                ST_DATA:  serial_line <= shift[0];
                default:  serial_line <= 1'b1;
            endcase

            busy <= (state != ST_IDLE) || !fifo_empty;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state   <= ST_START;
                        shift   <= fifo_data;
                        bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (!fifo_empty) begin
                            state <= ST_START;
                            shift <= fifo_data;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a queue-plus-frame-timer reference model
// predicts line, busy and in_ready every cycle; a receiver model decodes frames.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       serial_line;
    logic       busy;

    uart_tx #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .serial_line (serial_line),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: buffered bytes, remaining cycles of the current
    // frame, and the edges on which the last two frames started.
    logic [7:0] q[$];
    logic [7:0] acc_q[$];
    int         edge_n     = 0;
    int         frame_left = 0;
    int         cur_pop    = -1000;
    int         prev_pop   = -1000;
    logic [7:0] cur_byte   = 8'h00;
    logic [7:0] prev_byte  = 8'h00;
    logic       exp_busy   = 1'b0;
    logic       exp_ready  = 1'b1;

    // Receiver model state.
    logic       rx_active = 1'b0;
    int         rx_t      = 0;
    logic [7:0] rx_byte   = 8'h00;

    function automatic logic frame_bit(input int n, input int p, input logic [7:0] b);
        int off;
        int bi;
        off = n - p - 1;
        if (off < 0 || off >= FRAME) return 1'b1;
        bi = off / CPB;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        return b[bi-1];
    endfunction

    function automatic logic exp_line();
        return frame_bit(edge_n, cur_pop, cur_byte) & frame_bit(edge_n, prev_pop, prev_byte);
    endfunction

    task automatic model_reset();
        q.delete();
        acc_q.delete();
        frame_left = 0;
        cur_pop    = -1000;
        prev_pop   = -1000;
        exp_busy   = 1'b0;
        exp_ready  = 1'b1;
        rx_active  = 1'b0;
    endtask

    task automatic model_edge();
        int   pre;
        logic pop;
        edge_n++;
        pre      = q.size();
        pop      = (pre > 0) && (frame_left <= 1);
        exp_busy = (frame_left > 0) || (pre > 0);
        if (pop) begin
            prev_pop   = cur_pop;
            prev_byte  = cur_byte;
            cur_pop    = edge_n;
            cur_byte   = q.pop_front();
            frame_left = FRAME;
        end else if (frame_left > 0) begin
            frame_left--;
        end
        if (in_valid && pre < DEPTH) begin
            q.push_back(in_data);
            acc_q.push_back(in_data);
        end
        exp_ready = (q.size() < DEPTH);
    endtask

    task automatic rx_sample();
        int k;
        if (!rx_active) begin
            if (serial_line == 1'b0) begin
                rx_active = 1'b1;
                rx_t      = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == CPB / 2 && rx_t > CPB && rx_t < 9 * CPB) begin
                k = rx_t / CPB;
                rx_byte[k-1] = serial_line;
            end
            if (rx_t == 9 * CPB + CPB / 2) begin
                check_val("rx_stop", {31'b0, serial_line}, 32'd1);
                if (acc_q.size() == 0) begin
                    check_val("rx_unexpected", {24'b0, rx_byte}, 32'hFFFF_FFFF);
                end else begin
                    check_val("rx_byte", {24'b0, rx_byte}, {24'b0, acc_q.pop_front()});
                end
                $display("rx frame %02h at t=%0t", rx_byte, $time);
                rx_active = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("line",  {31'b0, serial_line}, {31'b0, exp_line()});
        check_val("busy",  {31'b0, busy},        {31'b0, exp_busy});
        check_val("ready", {31'b0, in_ready},    {31'b0, exp_ready});
        rx_sample();
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((q.size() > 0 || frame_left > 0 || exp_busy) && k < budget) begin
            step();
            k++;
        end
        check_val("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int         push_edge;
        int         t_low;
        int         t_busy;
        int         off;
        logic [9:0] bits;
        logic       saw_full;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_line",  {31'b0, serial_line}, 32'd1);
        check_val("reset_busy",  {31'b0, busy},        32'd0);
        check_val("reset_ready", {31'b0, in_ready},    32'd1);
        model_reset();
        rst = 1'b0;

        // Single 0xA5 frame: latency, mid-bit values and busy span
        send(8'hA5);
        push_edge = edge_n;
        t_low  = -1;
        t_busy = -1;
        bits   = '0;
        for (int k = 0; k < 120 && t_busy < 0; k++) begin
            step();
            if (t_low < 0) begin
                if (serial_line == 1'b0) t_low = edge_n;
            end else begin
                off = edge_n - t_low;
                if (off % CPB == CPB / 2 && off < FRAME) bits[off/CPB] = serial_line;
                if (busy == 1'b0 && t_busy < 0) t_busy = edge_n;
            end
        end
        check_val("a5_latency",   t_low - push_edge, 32'd2);
        check_val("a5_bits",      {22'b0, bits},     32'h34A);
        check_val("a5_busy_span", t_busy - t_low,    32'd40);
        wait_idle(100);

        // Every byte value, one at a time
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            wait_idle(200);
        end

        // Burst on consecutive cycles
        in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = 8'(i * 8'h11);
            step();
        end
        in_valid = 1'b0;
        wait_idle(400);

        // in_valid held high: buffer saturates, pushes follow pops
        saw_full = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 8'($urandom);
            step();
            if (!in_ready) saw_full = 1'b1;
        end
        in_valid = 1'b0;
        check_val("saw_full", {31'b0, saw_full}, 32'd1);
        wait_idle(400);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        wait_idle(400);

        // Reset during data bit 3 of a 0x0F frame with more bytes queued
        send(8'h0F);
        send(8'hAA);
        send(8'h55);
        for (int k = 0; k < 80 && (edge_n - cur_pop - 1) != 17; k++) begin
            step();
        end
        check_val("reset_reach", edge_n - cur_pop - 1, 32'd17);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_line",  {31'b0, serial_line}, 32'd1);
        check_val("midrst_busy",  {31'b0, busy},        32'd0);
        check_val("midrst_ready", {31'b0, in_ready},    32'd1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_val("held_rst_line", {31'b0, serial_line}, 32'd1);
        rst = 1'b0;
        send(8'h3C);
        check_val("post_rst_accept", acc_q.size(), 32'd1);
        wait_idle(200);

        check_val("all_received", acc_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
